march_sequencer: RTL and testbench

MARCH_SEQUENCER -- requirements
Module: march_sequencer

---
 rtl/march_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_march_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/march_sequencer.sv
// March C- sequencer: steps six march elements over an external address
// counter, issues read/write strobes with the background bit and checks read
// data one cycle after each read. Optional build macro
// MARCH_RETENTION_PAUSE_EN inserts a retention pause between E2 and E3.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef ADMD_LIUD
`define ADMD_LIUD 1'b0
`endif
`ifndef ADMD_PRUD
`define ADMD_PRUD 1'b1
`endif
`ifndef ADMD_PR_SEED
`define ADMD_PR_SEED 8'h01
`endif

module march_sequencer #(
    parameter int ADDR_WIDTH   = `ADDR_WIDTH,
    parameter int PAUSE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       admd_in,
    input  logic       rbit_in,
    output logic       s_out,
    output logic       r_out,
    output logic       hold_out,
    output logic       updwn_out,
    output logic       we_out,
    output logic       re_out,
    output logic       wbit_out,
    output logic [2:0] elem_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       fail_out
);

`ifdef MARCH_RETENTION_PAUSE_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_OP    = 3'd2,
        ST_DONE  = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;
    localparam int PW = $clog2(PAUSE_CYCLES + 1);
    logic [PW-1:0] pause_q, pause_d;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_OP   = 2'd2,
        ST_DONE = 2'd3
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic                  op_q, op_d;          // op index within element
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;        // completed addresses in element
    logic                  admd_q, admd_d;      // mode latched at INIT
    logic                  exp_q, exp_d;        // expected bit of last read
    logic                  chk_q, chk_d;        // a read result is due this cycle
    logic                  fail_q, fail_d;

    logic                  down_s, two_op_s, rd_s, dat_s, last_op_s, mismatch_s;
    logic [ADDR_WIDTH-1:0] term_s;

    // Element decode: direction, op count, op kind and data background.
    always_comb begin
        down_s   = (elem_q == 3'd3) || (elem_q == 3'd4);
        two_op_s = (elem_q >= 3'd1) && (elem_q <= 3'd4);
        rd_s     = (elem_q == 3'd5) || (two_op_s && (op_q == 1'b0));
        case (elem_q)
            3'd1, 3'd3: dat_s = op_q;
            3'd2, 3'd4: dat_s = ~op_q;
            default:    dat_s = 1'b0;
        endcase
        last_op_s  = !two_op_s || op_q;
        // PRUD sequences skip the all-zero address, so one visit fewer.
        term_s     = {ADDR_WIDTH{1'b1}} - ((admd_q == `ADMD_PRUD) ? ADDR_WIDTH'(1) : ADDR_WIDTH'(0));
        mismatch_s = chk_q && (rbit_in != exp_q);
    end

    // Next-state and output logic of the march FSM.
    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        admd_d    = admd_q;
        exp_d     = exp_q;
        chk_d     = 1'b0;
        fail_d    = fail_q | mismatch_s;
`ifdef MARCH_RETENTION_PAUSE_EN
        pause_d   = pause_q;
`endif
        s_out     = 1'b0;
        r_out     = 1'b0;
        hold_out  = 1'b1;
        updwn_out = 1'b0;
        we_out    = 1'b0;
        re_out    = 1'b0;
        wbit_out  = 1'b0;
        busy_out  = 1'b0;
        done_out  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_INIT;
                    elem_d  = 3'd0;
                    fail_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                busy_out  = 1'b1;
                s_out     = !down_s;
                r_out     = down_s;
                updwn_out = down_s;
                cnt_d     = '0;
                op_d      = 1'b0;
                admd_d    = admd_in;
                state_d   = ST_OP;
            end
            ST_OP: begin
                busy_out  = 1'b1;
                updwn_out = down_s;
                re_out    = rd_s;
                we_out    = !rd_s;
                wbit_out  = !rd_s && dat_s;
                if (rd_s) begin
                    exp_d = dat_s;
                    chk_d = 1'b1;
                end else begin
                    exp_d = exp_q;
                end
                if (!last_op_s) begin
                    op_d = 1'b1;
                end else if (cnt_q != term_s) begin
                    // Release hold so the counter steps on this edge.
                    op_d     = 1'b0;
                    hold_out = 1'b0;
                    cnt_d    = cnt_q + ADDR_WIDTH'(1);
                end else if (elem_q == 3'd5) begin
                    op_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    op_d   = 1'b0;
                    elem_d = elem_q + 3'd1;
`ifdef MARCH_RETENTION_PAUSE_EN
                    if (elem_q == 3'd2) begin
                        state_d = ST_PAUSE;
                        pause_d = '0;
                    end else begin
                        state_d = ST_INIT;
                    end
`else
                    state_d = ST_INIT;
`endif
                end
            end
`ifdef MARCH_RETENTION_PAUSE_EN
            ST_PAUSE: begin
                busy_out = 1'b1;
                if (pause_q == PW'(PAUSE_CYCLES - 1)) begin
                    state_d = ST_INIT;
                    pause_d = '0;
                end else begin
                    pause_d = pause_q + PW'(1);
                end
            end
`endif
            ST_DONE: begin
                done_out = 1'b1;
                if (start) begin
                    state_d = ST_INIT;
                    elem_d  = 3'd0;
                    fail_d  = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        elem_out = elem_q;
        // A read mismatch shows in the cycle the read data is presented.
        fail_out = fail_q | mismatch_s;
    end

    // State registers with asynchronous abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            elem_q  <= 3'd0;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            admd_q  <= `ADMD_LIUD;
            exp_q   <= 1'b0;
            chk_q   <= 1'b0;
            fail_q  <= 1'b0;
`ifdef MARCH_RETENTION_PAUSE_EN
            pause_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            admd_q  <= admd_d;
            exp_q   <= exp_d;
            chk_q   <= chk_d;
            fail_q  <= fail_d;
`ifdef MARCH_RETENTION_PAUSE_EN
            pause_q <= pause_d;
`endif
        end
    end

endmodule

// File: tb/tb_march_sequencer.sv
// Bench for march_sequencer: address counter and 1-bit memory model with
// fault injection, table of full-run scenarios plus hand-written corner cases.
`timescale 1ns/1ps
`ifndef ADMD_PR_SEED
`define ADMD_PR_SEED 8'h01
`endif

module tb_march_sequencer;
    localparam int AW = 8;
    localparam int PC = 16;
`ifdef MARCH_RETENTION_PAUSE_EN
    localparam int EXP_GAP = PC;
`else
    localparam int EXP_GAP = 0;
`endif
    localparam logic [7:0] SEED = `ADMD_PR_SEED;

    logic clk = 1'b0;
    logic rst, start, admd_in, rbit_in;
    logic s_out, r_out, hold_out, updwn_out, we_out, re_out, wbit_out;
    logic [2:0] elem_out;
    logic busy_out, done_out, fail_out;

    march_sequencer #(.ADDR_WIDTH(AW), .PAUSE_CYCLES(PC)) dut (
        .clk(clk), .rst(rst), .start(start), .admd_in(admd_in), .rbit_in(rbit_in),
        .s_out(s_out), .r_out(r_out), .hold_out(hold_out), .updwn_out(updwn_out),
        .we_out(we_out), .re_out(re_out), .wbit_out(wbit_out), .elem_out(elem_out),
        .busy_out(busy_out), .done_out(done_out), .fail_out(fail_out)
    );

    always #5 clk = ~clk;

    // address counter + memory model
    logic [7:0] addr_q;
    logic       mem [0:255];
    logic       cnt_mode, stk_en, stk_val;
    logic [7:0] stk_addr;

    function automatic logic [7:0] lfsr_next(input logic [7:0] a);
        return {a[6:0], a[7] ^ a[5] ^ a[4] ^ a[3]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= 8'h00;
            rbit_in <= 1'b0;
        end else begin
            if (s_out)          addr_q <= cnt_mode ? SEED : 8'h00;
            else if (r_out)     addr_q <= cnt_mode ? SEED : 8'hFF;
            else if (!hold_out) addr_q <= cnt_mode ? lfsr_next(addr_q)
                                                   : (updwn_out ? addr_q - 8'd1 : addr_q + 8'd1);
            if (we_out) mem[addr_q] <= wbit_out;
            rbit_in <= (stk_en && addr_q == stk_addr) ? stk_val : mem[addr_q];
        end
    end

    // run statistics
    int cyc, busy_cnt, idle_busy, updwn_bad, e1_distinct;
    int fail_cyc, r5_cyc, last_e2_cyc, e3_init_cyc;
    int ops [6];
    int hl  [6];
    logic [7:0] first_a [6];
    logic [7:0] last_a  [6];
    logic init_r [6];
    bit seen [256];

    always @(negedge clk) begin
        int e;
        cyc++;
        if (busy_out) busy_cnt++;
        if (busy_out && !we_out && !re_out && !s_out && !r_out && hold_out) idle_busy++;
        if ((s_out || r_out) && elem_out < 3'd6) begin
            init_r[elem_out] = r_out;
            if (elem_out == 3'd3) e3_init_cyc = cyc;
        end
        if ((we_out || re_out) && elem_out < 3'd6) begin
            e = int'(elem_out);
            if (ops[e] == 0) first_a[e] = addr_q;
            last_a[e] = addr_q;
            ops[e]++;
            if (!hold_out) hl[e]++;
            if (updwn_out != (e == 3 || e == 4)) updwn_bad++;
            if (e == 1 && !seen[addr_q]) begin seen[addr_q] = 1'b1; e1_distinct++; end
            if (e == 2) last_e2_cyc = cyc;
            if (e == 1 && re_out && addr_q == stk_addr && r5_cyc < 0) r5_cyc = cyc;
        end
        if (fail_out && fail_cyc < 0) fail_cyc = cyc;
    end

    task automatic clear_stats();
        busy_cnt = 0; idle_busy = 0; updwn_bad = 0; e1_distinct = 0;
        fail_cyc = -1; r5_cyc = -1; last_e2_cyc = 0; e3_init_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            ops[i] = 0; hl[i] = 0; first_a[i] = 8'h00; last_a[i] = 8'h00; init_r[i] = 1'b0;
        end
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    endtask

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       admd;
        logic       stk_en;
        logic       stk_val;
        logic [7:0] stk_addr;
        logic       glitch;     // toggle admd_in mid-E1
        logic       restart;    // extra start pulse mid-run
        logic       chk_rise;   // check fail timing vs E1 read of stk_addr
        int         exp_busy;
        logic       exp_fail;
    } scn_t;

    task automatic run_scn(input scn_t s, input int idx);
        int budget;
        int n;
        cnt_mode = s.admd; admd_in = s.admd;
        stk_en = s.stk_en; stk_val = s.stk_val; stk_addr = s.stk_addr;
        clear_stats();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check($sformatf("s%0d_start_state", idx), {28'd0, done_out, fail_out, busy_out, s_out},
              {28'd0, 1'b0, 1'b0, 1'b1, ~s.admd | s.admd});
        check($sformatf("s%0d_start_elem", idx), elem_out, 0);
        budget = 0;
        while (!done_out && budget < 5000) begin
            @(posedge clk); #1;
            budget++;
            if (s.glitch) admd_in = (budget >= 300 && budget < 400) ? ~s.admd : s.admd;
            start = (s.restart && budget == 700) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check($sformatf("s%0d_timeout", idx), done_out, 1);
        @(negedge clk); #1;
        n = s.admd ? 255 : 256;
        check($sformatf("s%0d_busy_cycles", idx), busy_cnt, s.exp_busy);
        check($sformatf("s%0d_done", idx), {done_out, busy_out}, {1'b1, 1'b0});
        check($sformatf("s%0d_fail", idx), fail_out, s.exp_fail);
        for (int e = 0; e < 6; e++)
            check($sformatf("s%0d_visits_e%0d", idx, e), hl[e], n - 1);
        check($sformatf("s%0d_updwn", idx), updwn_bad, 0);
        check($sformatf("s%0d_pause_gap", idx), e3_init_cyc - last_e2_cyc - 1, EXP_GAP);
        check($sformatf("s%0d_idle_busy", idx), idle_busy, EXP_GAP);
        check($sformatf("s%0d_e3_init_r", idx), init_r[3], 1);
        if (s.admd == 1'b0) begin
            check($sformatf("s%0d_e3_first_addr", idx), first_a[3], 255);
            check($sformatf("s%0d_e3_last_addr", idx), last_a[3], 0);
        end else begin
            check($sformatf("s%0d_e1_first_addr", idx), first_a[1], SEED);
            check($sformatf("s%0d_e1_distinct", idx), e1_distinct, 255);
        end
        if (s.chk_rise)
            check($sformatf("s%0d_fail_rise", idx), fail_cyc - r5_cyc, 1);
    endtask

    scn_t tbl [4];

    initial begin
        tbl[0] = '{admd:1'b0, stk_en:1'b0, stk_val:1'b0, stk_addr:8'd5,   glitch:1'b0, restart:1'b1,
                   chk_rise:1'b0, exp_busy:2566 + EXP_GAP, exp_fail:1'b0};
        tbl[1] = '{admd:1'b1, stk_en:1'b0, stk_val:1'b0, stk_addr:8'd5,   glitch:1'b0, restart:1'b0,
                   chk_rise:1'b0, exp_busy:2556 + EXP_GAP, exp_fail:1'b0};
        tbl[2] = '{admd:1'b0, stk_en:1'b1, stk_val:1'b1, stk_addr:8'd5,   glitch:1'b0, restart:1'b0,
                   chk_rise:1'b1, exp_busy:2566 + EXP_GAP, exp_fail:1'b1};
        tbl[3] = '{admd:1'b0, stk_en:1'b1, stk_val:1'b0, stk_addr:8'd200, glitch:1'b1, restart:1'b0,
                   chk_rise:1'b0, exp_busy:2566 + EXP_GAP, exp_fail:1'b1};

        for (int i = 0; i < 256; i++) mem[i] = 1'b0;
        cyc = 0; cnt_mode = 1'b0; stk_en = 1'b0; stk_val = 1'b0; stk_addr = 8'd5;
        clear_stats();
        rst = 1'b1; start = 1'b0; admd_in = 1'b0;
        #1;
        check("reset_outputs", {s_out, r_out, hold_out, updwn_out, we_out, re_out, wbit_out,
                                busy_out, done_out, fail_out}, 10'b0010000000);
        check("reset_elem", elem_out, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("idle_outputs", {s_out, r_out, hold_out, we_out, re_out, busy_out, done_out},
              7'b0010000);

        for (int i = 0; i < 4; i++) run_scn(tbl[i], i);

        // abort during OP of E2
        cnt_mode = 1'b0; admd_in = 1'b0; stk_en = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        begin
            int b;
            b = 0;
            while (!(elem_out == 3'd2 && (we_out || re_out)) && b < 3000) begin
                @(posedge clk); #1; b++;
            end
            check("reach_e2_op", elem_out, 2);
            repeat (37) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            check("abort_strobes", {s_out, r_out, we_out, re_out, wbit_out, hold_out, busy_out},
                  7'b0000010);
            check("abort_elem", elem_out, 0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("abort_no_strobe", {we_out, re_out, s_out, r_out, done_out}, 5'b00000);
            end
            #2 rst = 1'b0;
        end
        run_scn(tbl[0], 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
